// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine coin paths: amount width,
// coin denominations and the payout FSM state encoding.
package vending_pkg;

  localparam int AMT_W     = 5;
  localparam int COIN_FIVE = 5;
  localparam int COIN_TEN  = 10;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    REQ,
    DONE,
    JAM
  } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Coin hopper handshake: one coin_req per coin, denomination on coin_ten,
// hopper answers with coin_ack once the coin has dropped.
interface change_dispenser_if;

  logic coin_req;
  logic coin_ten;
  logic coin_ack;

  modport master (output coin_req, output coin_ten, input coin_ack);
  modport slave  (input coin_req, input coin_ten, output coin_ack);

endinterface

// File: rtl/coin_stock.sv
// Coin stock counter: saturating add on refill, decrement that never goes
// below zero.
module coin_stock #(
  parameter int W    = 5,
  parameter int INIT = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         add_en,
  input  logic [W-1:0] add_amt,
  input  logic         dec,
  output logic [W-1:0] count
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, count} + {1'b0, add_amt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= W'(INIT);
    end else if (add_en) begin
      count <= sum[W] ? '1 : sum[W-1:0];
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: loads a change amount from vending_mach and pays it
// out greedily (10 Rs then 5 Rs) over the hopper handshake.
module change_dispenser #(
  parameter int AMT_W       = vending_pkg::AMT_W,
  parameter int STOCK_W     = 5,
  parameter int INIT_TEN    = 5,
  parameter int INIT_FIVE   = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               give,
  input  logic [AMT_W-1:0]   change,
  input  logic               refill,
  input  logic [STOCK_W-1:0] ten_added,
  input  logic [STOCK_W-1:0] five_added,
  change_dispenser_if.master hop,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   short_amt,
  output logic               jam,
  output logic [STOCK_W-1:0] ten_stock,
  output logic [STOCK_W-1:0] five_stock
);

  import vending_pkg::*;

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state;
  logic [AMT_W-1:0]   remaining;
  logic [TMR_W-1:0]   timer;
  logic               load;
  logic               add_en;
  logic               dec_ten;
  logic               dec_five;

  always_comb begin
    load     = (state == IDLE) && give && (change != '0);
    add_en   = (state == IDLE) && refill;
    dec_ten  = (state == REQ) && hop.coin_ack && hop.coin_ten;
    dec_five = (state == REQ) && hop.coin_ack && !hop.coin_ten;
  end

  // Refill lands on the same edge as a load, so SEL sees the new stock.
  coin_stock #(.W(STOCK_W), .INIT(INIT_TEN)) u_ten_stock (
    .clk     (clk),
    .reset   (reset),
    .add_en  (add_en),
    .add_amt (ten_added),
    .dec     (dec_ten),
    .count   (ten_stock)
  );

  coin_stock #(.W(STOCK_W), .INIT(INIT_FIVE)) u_five_stock (
    .clk     (clk),
    .reset   (reset),
    .add_en  (add_en),
    .add_amt (five_added),
    .dec     (dec_five),
    .count   (five_stock)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      timer        <= '0;
      hop.coin_req <= 1'b0;
      hop.coin_ten <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      short        <= 1'b0;
      short_amt    <= '0;
      jam          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            remaining <= change;
            short     <= 1'b0;
            short_amt <= '0;
            busy      <= 1'b1;
            state     <= SEL;
          end
        end
        SEL: begin
          timer <= '0;
          if (remaining == '0) begin
            busy  <= 1'b0;
            state <= DONE;
          end else if ((remaining >= AMT_W'(COIN_TEN)) && (ten_stock != '0)) begin
            hop.coin_req <= 1'b1;
            hop.coin_ten <= 1'b1;
            state        <= REQ;
          end else if ((remaining >= AMT_W'(COIN_FIVE)) && (five_stock != '0)) begin
            hop.coin_req <= 1'b1;
            hop.coin_ten <= 1'b0;
            state        <= REQ;
          end else begin
            short     <= 1'b1;
            short_amt <= remaining;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        REQ: begin
          // An ack on the last timeout cycle still counts as a delivered coin.
          if (hop.coin_ack) begin
            hop.coin_req <= 1'b0;
            remaining    <= remaining - (hop.coin_ten ? AMT_W'(COIN_TEN) : AMT_W'(COIN_FIVE));
            state        <= SEL;
          end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
            hop.coin_req <= 1'b0;
            busy         <= 1'b0;
            jam          <= 1'b1;
            state        <= JAM;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        JAM: begin
          state <= JAM;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected hopper
// requests and done reports, a monitor pops and compares them.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       give;
  logic [4:0] change;
  logic       refill;
  logic [4:0] ten_added;
  logic [4:0] five_added;
  logic       busy;
  logic       done;
  logic       short;
  logic [4:0] short_amt;
  logic       jam;
  logic [4:0] ten_stock;
  logic [4:0] five_stock;

  change_dispenser_if hop ();

  change_dispenser #(
    .AMT_W       (5),
    .STOCK_W     (5),
    .INIT_TEN    (5),
    .INIT_FIVE   (5),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .give       (give),
    .change     (change),
    .refill     (refill),
    .ten_added  (ten_added),
    .five_added (five_added),
    .hop        (hop),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .short_amt  (short_amt),
    .jam        (jam),
    .ten_stock  (ten_stock),
    .five_stock (five_stock)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    bit ten;
    bit shrt;
    int amt;
    int ts;
    int fs;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;
  bit  ack_en;
  int  ack_delay;
  int  ack_cnt;
  logic prev_req;
  logic prev_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_req(input bit ten);
    ev_t e;
    e = '{is_done: 1'b0, ten: ten, shrt: 1'b0, amt: 0, ts: 0, fs: 0};
    sb.push_back(e);
  endfunction

  function automatic void push_done(input bit shrt, input int amt, input int ts, input int fs);
    ev_t e;
    e = '{is_done: 1'b1, ten: 1'b0, shrt: shrt, amt: amt, ts: ts, fs: fs};
    sb.push_back(e);
  endfunction

  // Hopper model: acks ack_delay cycles after a request rises.
  initial begin
    hop.coin_ack = 1'b0;
    ack_cnt      = 0;
    forever begin
      @(negedge clk);
      if (hop.coin_req && !hop.coin_ack) begin
        if (ack_en && (ack_cnt + 1 >= ack_delay)) begin
          hop.coin_ack = 1'b1;
          ack_cnt      = 0;
        end else begin
          ack_cnt++;
        end
      end else begin
        hop.coin_ack = 1'b0;
        ack_cnt      = 0;
      end
    end
  end

  initial begin
    ev_t e;
    prev_req  = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (hop.coin_req && !prev_req) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got req ten=%0d expected no event", hop.coin_ten);
        end else begin
          e = sb.pop_front();
          check("req_kind", 32'(0), 32'(e.is_done));
          check("req_ten", 32'(hop.coin_ten), 32'(e.ten));
        end
      end
      if (done) begin
        check("done_single", 32'(prev_done), 32'(0));
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done expected no event");
        end else begin
          e = sb.pop_front();
          check("done_kind", 32'(1), 32'(e.is_done));
          check("done_short", 32'(short), 32'(e.shrt));
          check("done_short_amt", 32'(short_amt), 32'(e.amt));
          check("done_ten_stock", 32'(ten_stock), 32'(e.ts));
          check("done_five_stock", 32'(five_stock), 32'(e.fs));
        end
      end
      prev_req  = hop.coin_req;
      prev_done = done;
    end
  end

  task automatic give_pulse(input int amt);
    give   = 1'b1;
    change = 5'(amt);
    @(negedge clk);
    give   = 1'b0;
  endtask

  task automatic give_lat(input int amt, input bit want_done, output int cyc);
    give   = 1'b1;
    change = 5'(amt);
    @(negedge clk);
    give = 1'b0;
    cyc  = 1;
    while (!(want_done ? done : hop.coin_req) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb.size()), 32'(0));
  endtask

  task automatic do_refill(input int t, input int f);
    refill     = 1'b1;
    ten_added  = 5'(t);
    five_added = 5'(f);
    @(negedge clk);
    refill = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    reset = 1'b1; give = 1'b0; change = '0; refill = 1'b0;
    ten_added = '0; five_added = '0;
    ack_en = 1'b1; ack_delay = 2;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_req", 32'(hop.coin_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_short", 32'(short), 0);
    check("rst_short_amt", 32'(short_amt), 0);
    check("rst_jam", 32'(jam), 0);
    check("rst_ten", 32'(ten_stock), 5);
    check("rst_five", 32'(five_stock), 5);

    // 15 Rs from 5/5: one ten, one five
    push_req(1); push_req(0); push_done(0, 0, 4, 4);
    give_lat(15, 1'b0, cyc);
    check("lat_req", 32'(cyc), 2);
    drain("t1_sb");
    check("t1_busy", 32'(busy), 0);

    // 31 Rs from 4/4: three tens, 1 Rs residue is short
    push_req(1); push_req(1); push_req(1); push_done(1, 1, 1, 4);
    give_pulse(31);
    drain("t1b_sb");

    // 15 Rs from 1/4 leaves 0/3
    push_req(1); push_req(0); push_done(0, 0, 0, 3);
    give_pulse(15);
    drain("t1c_sb");

    // 20 Rs with no tens and three fives: 5 Rs short
    push_req(0); push_req(0); push_req(0); push_done(1, 5, 0, 0);
    give_pulse(20);
    drain("t2_sb");
    repeat (3) @(negedge clk);
    check("short_held", 32'(short), 1);
    check("short_amt_held", 32'(short_amt), 5);

    // Empty stock: done 3 cycles after give
    push_done(1, 10, 0, 0);
    give_lat(10, 1'b1, cyc);
    check("lat_done", 32'(cyc), 3);
    drain("zero_sb");

    give_pulse(0);
    repeat (5) @(negedge clk);
    check("zero_give_busy", 32'(busy), 0);
    check("zero_give_short", 32'(short_amt), 10);

    do_refill(31, 5);
    check("refill1_ten", 32'(ten_stock), 31);
    check("refill1_five", 32'(five_stock), 5);
    do_refill(5, 31);
    check("refill_sat_ten", 32'(ten_stock), 31);
    check("refill_sat_five", 32'(five_stock), 31);

    // 25 Rs; a second give and a refill while requesting are both ignored
    push_req(1); push_req(1); push_req(0); push_done(0, 0, 29, 30);
    give_lat(25, 1'b0, cyc);
    give = 1'b1; change = 5'd10;
    refill = 1'b1; ten_added = 5'd3; five_added = 5'd3;
    @(negedge clk);
    give = 1'b0; refill = 1'b0;
    drain("t4_sb");
    check("t4_ten", 32'(ten_stock), 29);
    check("t4_five", 32'(five_stock), 30);

    // give with refill in IDLE
    push_req(1); push_done(0, 0, 30, 30);
    give = 1'b1; change = 5'd10;
    refill = 1'b1; ten_added = 5'd2; five_added = 5'd0;
    @(negedge clk);
    give = 1'b0; refill = 1'b0;
    drain("give_refill_sb");

    // Hopper never acks
    ack_en = 1'b0;
    push_req(0);
    give_lat(5, 1'b0, cyc);
    n = 0;
    while (hop.coin_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("req_hold", 32'(n), 15);
    check("jam_set", 32'(jam), 1);
    check("jam_req", 32'(hop.coin_req), 0);
    check("jam_busy", 32'(busy), 0);
    give_pulse(10);
    repeat (5) @(negedge clk);
    check("jam_give_req", 32'(hop.coin_req), 0);
    check("jam_sticky", 32'(jam), 1);
    check("jam_sb", 32'(sb.size()), 0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("jam_cleared", 32'(jam), 0);
    check("rst2_ten", 32'(ten_stock), 5);

    // Reset in the middle of a request
    push_req(1);
    give_lat(10, 1'b0, cyc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_req", 32'(hop.coin_req), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ten", 32'(ten_stock), 5);
    check("abort_five", 32'(five_stock), 5);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_quiet", 32'(hop.coin_req), 0);
    check("abort_sb", 32'(sb.size()), 0);

    // Ack on the final timeout cycle
    ack_en = 1'b1; ack_delay = 15;
    push_req(1); push_done(0, 0, 4, 5);
    give_pulse(10);
    drain("late_ack_sb");
    check("late_ack_jam", 32'(jam), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
